// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester/arbiter bundle for the shared 4:1 mux.
//   req      requester -> arbiter  request lines, one per requester
//   gnt      arbiter -> requester  one-hot registered grant
//   sel_s1   arbiter -> mux        bit 0 of the granted index
//   sel_s0   arbiter -> mux        bit 1 of the granted index
//   busy     arbiter -> requester  any grant active
//   preempt  arbiter -> requester  one-cycle pulse on a timeout-forced release
// Modports: master = requester side, slave = arbiter side.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       sel_s1;
  logic       sel_s0;
  logic       busy;
  logic       preempt;

  modport master (output req, input gnt, sel_s1, sel_s0, busy, preempt);
  modport slave  (input req, output gnt, sel_s1, sel_s0, busy, preempt);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving the select pair of a shared
// 4:1 datapath mux. One owner at a time; the owner keeps the grant until it
// drops req, then the next requester (searching upward from last+1, with wrap)
// takes over with no idle gap.
// Optional feature, macro ARB_TIMEOUT_EN: an owner that has held the grant for
// MAX_HOLD cycles is released when another requester is waiting; preempt
// pulses on that edge. Without the macro the hold counter is absent and
// preempt is tied low.
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave modport of mux4_rr_arbiter_if (req in; gnt, sel_s1, sel_s0,
//          busy, preempt out, all registered)
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  mux4_rr_arbiter_if.slave     bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0] state;
  logic [1:0] last;      // last granted index; equals the owner while in OWN
  logic [3:0] gnt_q;
  logic       sel_s1_q;
  logic       sel_s0_q;
  logic       preempt_q;

  // Round-robin search: first set bit of r strictly after ptr, wrapping, with
  // ptr itself checked last. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    // Walk from the farthest candidate back so the nearest one wins.
    for (int k = 4; k >= 1; k--) begin
      c = ptr + 2'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  logic [3:0] others;
  logic       own_req;
  logic       to_hit;
  logic [2:0] pick;
  logic       do_grant;
  logic       go_idle;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
`endif

  always_comb begin
    own_req = bus.req[last];
    others  = bus.req & ~(4'b0001 << last);
`ifdef ARB_TIMEOUT_EN
    to_hit  = (state == S_OWN) && own_req && (hold_q == HOLD_LIM) && (|others);
`else
    to_hit  = 1'b0;
`endif
    // In OWN the owner never wins its own re-arbitration: on release its req
    // bit is already low, and on a timeout it must be skipped.
    pick     = rr_pick((state == S_OWN) ? others : bus.req, last);
    do_grant = pick[2] && ((state == S_IDLE) || !own_req || to_hit);
    go_idle  = (state == S_OWN) && !own_req && !pick[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last      <= 2'd3;
      gnt_q     <= 4'b0000;
      sel_s1_q  <= 1'b0;
      sel_s0_q  <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      if (do_grant) begin
        state     <= S_OWN;
        last      <= pick[1:0];
        gnt_q     <= 4'b0001 << pick[1:0];
        sel_s1_q  <= pick[0];
        sel_s0_q  <= pick[1];
        preempt_q <= to_hit;
      end else if (go_idle) begin
        // sel keeps its last value so the mux output does not move.
        state <= S_IDLE;
        gnt_q <= 4'b0000;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Counts cycles of unchanged ownership; saturates at the limit so a lone
  // owner keeps the grant and is released as soon as someone else asks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
    end else if (do_grant) begin
      hold_q <= 8'd0;
    end else if (state == S_OWN && own_req && hold_q != HOLD_LIM) begin
      hold_q <= hold_q + 8'd1;
    end
  end
`endif

  assign bus.gnt     = gnt_q;
  assign bus.sel_s1  = sel_s1_q;
  assign bus.sel_s0  = sel_s0_q;
  assign bus.busy    = (state == S_OWN);
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Testbench for mux4_rr_arbiter: directed steps followed by random requests,
// every cycle compared with a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;
  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: owner index (-1 when idle), round-robin pointer, cycles held.
  int m_owner, m_last, m_hold, m_sel;
  bit m_pre;

  // Observed-grant starvation tracking.
  int wait_cnt [4];
  logic [3:0] prev_gnt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_from(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_last = 3; m_hold = 0; m_sel = 0; m_pre = 1'b0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    prev_gnt = 4'b0000;
  endtask

  task automatic m_grant(input int w);
    m_owner = w; m_last = w; m_sel = w; m_hold = 0;
  endtask

  task automatic m_step(input logic [3:0] r);
    logic [3:0] oth;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      if (r != 4'b0) m_grant(next_from(r, m_last));
    end else begin
      oth = r & ~(4'b0001 << m_owner);
      if (!r[m_owner]) begin
        if (oth != 4'b0) m_grant(next_from(oth, m_owner));
        else m_owner = -1;
      end else if (TO && m_hold >= MH - 1 && oth != 4'b0) begin
        m_grant(next_from(oth, m_owner));
        m_pre = 1'b1;
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check({tag, ".gnt"},     {4'b0, bus.gnt}, {4'b0, eg});
    check({tag, ".busy"},    {7'b0, bus.busy}, {7'b0, (m_owner >= 0)});
    check({tag, ".sel_s1"},  {7'b0, bus.sel_s1}, {7'b0, m_sel[0]});
    check({tag, ".sel_s0"},  {7'b0, bus.sel_s0}, {7'b0, m_sel[1]});
    check({tag, ".preempt"}, {7'b0, bus.preempt}, {7'b0, m_pre});
  endtask

  // One clock: model sees the req present at the edge, outputs sampled 1ns later.
  task automatic tick(input string tag);
    logic [3:0] r;
    int j;
    r = bus.req;
    @(posedge clk);
    m_step(r);
    #1;
    compare_all(tag);
    check({tag, ".onehot"}, {7'b0, ($countones(bus.gnt) <= 1)}, 8'd1);
    // Starvation: count distinct grants to others while requester i waits.
    if (bus.gnt != prev_gnt && bus.gnt != 4'b0) begin
      j = $clog2(bus.gnt);
      for (int i = 0; i < 4; i++) begin
        if (i == j) wait_cnt[i] = 0;
        else if (r[i]) wait_cnt[i]++;
        if (i != j) check($sformatf("%s.starve%0d", tag, i),
                          {7'b0, (wait_cnt[i] <= 3)}, 8'd1);
      end
    end
    for (int i = 0; i < 4; i++) if (!r[i]) wait_cnt[i] = 0;
    prev_gnt = bus.gnt;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = 4'b0000;
    m_reset();
    #12;
    compare_all("reset");
    rst_n = 1'b1;

    // Two requesters: index 0 first, then 2 after 0 drops.
    bus.req = 4'b0101;
    tick("t1a");
    check("t1a.gnt_lit", {4'b0, bus.gnt}, 8'h01);
    #1 bus.req = 4'b0100;
    tick("t1b");
    check("t1b.gnt_lit", {4'b0, bus.gnt}, 8'h04);
    check("t1b.s0_lit", {7'b0, bus.sel_s0}, 8'd1);

    // Owner 2 with 1 and 3 pending: 3 before 1, then wrap to 1.
    #1 bus.req = 4'b1110;
    tick("t2a");
    #1 bus.req = 4'b1010;
    tick("t2b");
    check("t2b.gnt_lit", {4'b0, bus.gnt}, 8'h08);
    #1 bus.req = 4'b0010;
    tick("t2c");
    check("t2c.gnt_lit", {4'b0, bus.gnt}, 8'h02);
    #1 bus.req = 4'b0000;
    tick("t2d");
    tick("t2e");

    // Single requester for three cycles, then idle.
    #1 bus.req = 4'b0010;
    for (int i = 0; i < 3; i++) tick("t3");
    #1 bus.req = 4'b0000;
    tick("t3end");
    check("t3end.busy_lit", {7'b0, bus.busy}, 8'd0);

    // All requesting: timeout rotation or a fixed owner, depending on build.
    #1 bus.req = 4'b1111;
    for (int i = 0; i < 4 * MH + 3; i++) tick("t4");
    #1 bus.req = 4'b0000;
    tick("t4end");
    tick("t4idle");

    // Asynchronous reset in the middle of a grant.
    #1 bus.req = 4'b0100;
    tick("t5a");
    tick("t5b");
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    compare_all("t5rst");
    check("t5rst.gnt_lit", {4'b0, bus.gnt}, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.req = 4'b1111;
    prev_gnt = bus.gnt;
    tick("t5c");
    check("t5c.gnt_lit", {4'b0, bus.gnt}, 8'h01);

    // Random requests; owners holding a few cycles to exercise timeout too.
    for (int n = 0; n < 10000; n++) begin
      #1;
      if ($urandom_range(0, 2) != 0) bus.req = 4'($urandom_range(0, 15));
      tick("rnd");
      if (bus.gnt != 4'b0)
        check("rnd.selidx", {6'b0, bus.sel_s0, bus.sel_s1}, 8'($clog2(bus.gnt)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
